// File: rtl/gate_unit_scheduler.sv
// rtl/gate_unit_scheduler.sv - round-robin scheduler sharing one mux-based NAND/NOR unit
// AND/OR are two passes: NAND/NOR first, then the same unit self-inverts the result.
module gate_unit_scheduler #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*2-1:0] req_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_data,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, RESP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr, id_q, grant_id, cand;
  logic           grant_any;
  logic [W-1:0]   a_q, b_q, tmp, data_q;
  logic [1:0]     op_q;
  logic [W-1:0]   unit_x, unit_y, unit_out;
  logic           unit_m;

  // Search starts one past the last grant so every requester gets a turn.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
    end
  end

  // The single shared gate unit; PASS2 feeds tmp to both inputs to invert it.
  always_comb begin
    unit_x = (state == PASS2) ? tmp : a_q;
    unit_y = (state == PASS2) ? tmp : b_q;
    unit_m = op_q[0];
    for (int i = 0; i < W; i++) begin
      unit_out[i] = unit_x[i] ? (unit_m ? 1'b0 : ~unit_y[i])
                              : (unit_m ? ~unit_y[i] : 1'b1);
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (grant_any) begin
          req_ready[grant_id] = rst_n;
          state_nxt           = PASS1;
        end
      end
      PASS1:   state_nxt = op_q[1] ? PASS2 : RESP;
      PASS2:   state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= IDW'(NREQ - 1);
      id_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      tmp    <= '0;
      data_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant_any) begin
            ptr  <= grant_id;
            id_q <= grant_id;
            a_q  <= req_a[int'(grant_id)*W +: W];
            b_q  <= req_b[int'(grant_id)*W +: W];
            op_q <= req_op[int'(grant_id)*2 +: 2];
          end
        end
        PASS1: begin
          tmp <= unit_out;
          if (!op_q[1]) data_q <= unit_out;
        end
        PASS2:   data_q <= unit_out;
        default: ;
      endcase
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_gate_unit_scheduler.sv
// tb/tb_gate_unit_scheduler.sv - directed self-checking bench for gate_unit_scheduler
module tb_gate_unit_scheduler;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [NREQ*2-1:0] req_op;
  logic              rsp_valid, rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_data;
  logic              busy;

  int n_cmp = 0;
  int n_bad = 0;

  gate_unit_scheduler #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    req_op[id*2 +: 2] = op;
  endtask

  // Issues one request from an idle cycle and records what the DUT did.
  task automatic run_op(input int id, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                        output logic [3:0] rdy0, output int extra, output int lat,
                        output logic [7:0] data, output logic [1:0] rid, output logic [15:0] bh);
    extra = 0; lat = -1; data = '0; rid = '0; bh = '0;
    set_req(id, a, b, op);
    req_valid = '0;
    req_valid[id] = 1'b1;
    #1;
    rdy0 = req_ready;
    bh[0] = busy;
    @(negedge clk);
    req_valid = '0;
    #1;
    for (int c = 1; c <= 10; c++) begin
      bh[c] = busy;
      if (req_ready != '0) extra++;
      if (rsp_valid) begin
        lat = c; data = rsp_data; rid = rsp_id;
        break;
      end
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    #1;
    if (lat >= 0) bh[lat+1] = busy;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b1; req_a = '0; req_b = '0; req_op = '0;
    @(negedge clk);
    #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_data !== 8'h00) begin n_bad++; $display("FAIL reset_rsp_data got %h want 00", rsp_data); end
    n_cmp++; if (rsp_id !== 2'd0) begin n_bad++; $display("FAIL reset_rsp_id got %0d want 0", rsp_id); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_nand;
    logic [3:0] r0; int ex, lat; logic [7:0] d; logic [1:0] id; logic [15:0] bh;
    run_op(0, 8'hF0, 8'hCC, 2'b00, r0, ex, lat, d, id, bh);
    n_cmp++; if (r0 !== 4'b0001) begin n_bad++; $display("FAIL nand_ready got %b want 0001", r0); end
    n_cmp++; if (ex !== 0) begin n_bad++; $display("FAIL nand_ready_once got %0d extra want 0", ex); end
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL nand_latency got %0d want 2", lat); end
    n_cmp++; if (d !== 8'h3F) begin n_bad++; $display("FAIL nand_data got %h want 3f", d); end
    n_cmp++; if (id !== 2'd0) begin n_bad++; $display("FAIL nand_id got %0d want 0", id); end
  endtask

  task automatic test_nor_or;
    logic [3:0] r0; int ex, lat; logic [7:0] d; logic [1:0] id; logic [15:0] bh;
    run_op(2, 8'hF0, 8'h0C, 2'b01, r0, ex, lat, d, id, bh);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL nor_latency got %0d want 2", lat); end
    n_cmp++; if (d !== 8'h03) begin n_bad++; $display("FAIL nor_data got %h want 03", d); end
    run_op(2, 8'hF0, 8'h0C, 2'b11, r0, ex, lat, d, id, bh);
    n_cmp++; if (r0 !== 4'b0100) begin n_bad++; $display("FAIL or_ready got %b want 0100", r0); end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL or_latency got %0d want 3", lat); end
    n_cmp++; if (d !== 8'hFC) begin n_bad++; $display("FAIL or_data got %h want fc", d); end
    n_cmp++; if (id !== 2'd2) begin n_bad++; $display("FAIL or_id got %0d want 2", id); end
  endtask

  task automatic test_and;
    logic [3:0] r0; int ex, lat; logic [7:0] d; logic [1:0] id; logic [15:0] bh;
    run_op(3, 8'hF0, 8'hCC, 2'b10, r0, ex, lat, d, id, bh);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL and_latency got %0d want 3", lat); end
    n_cmp++; if (d !== 8'hC0) begin n_bad++; $display("FAIL and_data got %h want c0", d); end
    n_cmp++; if (id !== 2'd3) begin n_bad++; $display("FAIL and_id got %0d want 3", id); end
    n_cmp++; if (bh[4:0] !== 5'b01110) begin n_bad++; $display("FAIL and_busy_cycles got %b want 01110", bh[4:0]); end
  endtask

  task automatic test_round_robin;
    int got, multi;
    int order [6];
    int exp_order [6] = '{0, 1, 2, 3, 0, 1};
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 8'h0F, 8'hF0, 2'b00);
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    got = 0; multi = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      #1;
      if (req_ready != '0) begin
        if ($countones(req_ready) != 1) multi++;
        for (int b = 0; b < NREQ; b++) if (req_ready[b]) order[got] = b;
        got++;
      end
      @(negedge clk);
    end
    req_valid = '0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if ($countones(req_ready) > 1) multi++;
      @(negedge clk);
    end
    n_cmp++; if (got !== 6) begin n_bad++; $display("FAIL rr_grant_count got %0d want 6", got); end
    n_cmp++; if (multi !== 0) begin n_bad++; $display("FAIL rr_onehot got %0d multi-grant cycles want 0", multi); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (i < got && order[i] !== exp_order[i]) begin
        n_bad++; $display("FAIL rr_order[%0d] got %0d want %0d", i, order[i], exp_order[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] d0; logic [1:0] i0; int bad; bit found;
    rsp_ready = 1'b0;
    set_req(1, 8'hAA, 8'h0F, 2'b00);
    set_req(2, 8'h33, 8'h55, 2'b00);
    req_valid = 4'b0010;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL bp_accept1 got %b want 0010", req_ready); end
    @(negedge clk);
    req_valid = 4'b0100;
    #1;
    found = 0;
    for (int c = 0; c < 10; c++) begin
      if (rsp_valid) begin found = 1; break; end
      @(negedge clk);
      #1;
    end
    d0 = rsp_data; i0 = rsp_id;
    n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL bp_rsp_timeout got no rsp_valid want rsp_valid"); end
    n_cmp++; if (d0 !== 8'hF5) begin n_bad++; $display("FAIL bp_data got %h want f5", d0); end
    n_cmp++; if (i0 !== 2'd1) begin n_bad++; $display("FAIL bp_id got %0d want 1", i0); end
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      #1;
      if (rsp_valid !== 1'b1 || rsp_data !== d0 || rsp_id !== i0 || req_ready !== 4'b0000) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL bp_hold got %0d unstable cycles want 0", bad); end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL bp_next_accept got %b want 0100", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    found = 0;
    for (int c = 0; c < 10; c++) begin
      if (rsp_valid) begin found = 1; break; end
      @(negedge clk);
      #1;
    end
    n_cmp++; if (rsp_data !== 8'hEE || rsp_id !== 2'd2 || !found) begin
      n_bad++; $display("FAIL bp_second_rsp got %h/id%0d want ee/id2", rsp_data, rsp_id);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int lat;
    set_req(3, 8'hF0, 8'hCC, 2'b10);
    req_valid = 4'b1000;
    #1;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rm_busy_before got %b want 1", busy); end
    rst_n = 1'b0;
    set_req(0, 8'hFF, 8'h0F, 2'b00);
    set_req(1, 8'h0F, 8'hF0, 2'b00);
    req_valid = 4'b0011;
    #1;
    n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rm_flags got valid=%b busy=%b want 0 0", rsp_valid, busy); end
    n_cmp++; if (rsp_data !== 8'h00 || rsp_id !== 2'd0) begin n_bad++; $display("FAIL rm_data got %h/id%0d want 00/id0", rsp_data, rsp_id); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL rm_ready_in_reset got %b want 0000", req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL rm_first_grant got %b want 0001", req_ready); end
    @(negedge clk);
    req_valid = 4'b0010;
    #1;
    lat = -1;
    for (int c = 1; c <= 10; c++) begin
      if (rsp_valid) begin lat = c; break; end
      @(negedge clk);
      #1;
    end
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL rm_latency got %0d want 2", lat); end
    n_cmp++; if (rsp_id !== 2'd0 || rsp_data !== 8'hF0) begin n_bad++; $display("FAIL rm_rsp got %h/id%0d want f0/id0", rsp_data, rsp_id); end
    @(negedge clk);
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL rm_second_grant got %b want 0010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    lat = -1;
    for (int c = 1; c <= 10; c++) begin
      if (rsp_valid) begin lat = c; break; end
      @(negedge clk);
      #1;
    end
    n_cmp++; if (rsp_id !== 2'd1 || rsp_data !== 8'hFF || lat < 0) begin n_bad++; $display("FAIL rm_second_rsp got %h/id%0d want ff/id1", rsp_data, rsp_id); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_nand();
    test_nor_or();
    test_and();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gate_unit_scheduler.md
# gate_unit_scheduler

Time-shares one mux-based universal gate unit (bitwise NAND/NOR built from 2:1 muxes) among NREQ requesters. A round-robin arbiter grants requests. AND and OR are sequenced as two passes through the shared unit. Results return on a single valid/ready response channel tagged with the requester index. The block sits between several client state machines and the one gate datapath instance, so the datapath is never duplicated.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 8, operand/result width in bits (bitwise operation)
- IDW, $clog2(NREQ), width of requester tag

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset; one clock, async assert, sync deassert handled upstream
- req_valid  input  NREQ  request pending, bit i = requester i
- req_ready  output  NREQ  one-hot accept strobe; at most one bit high
- req_a  input  NREQ*W  operand A, requester i in bits [i*W +: W]
- req_b  input  NREQ*W  operand B, same packing
- req_op  input  NREQ*2  opcode, requester i in bits [i*2 +: 2]: 00 NAND, 01 NOR, 10 AND, 11 OR
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer accepts result
- rsp_id  output  IDW  index of the requester that owns the result
- rsp_data  output  W  result
- busy  output  1  high in any state except IDLE

## Operation
- Shared unit is combinational and bitwise. It takes operands x, y and a mode bit m:
  - m=0: y_out = x ? ~y : 1 (NAND)
  - m=1: y_out = x ? 0 : ~y (NOR)
- Exactly one instance of the shared unit exists. All passes go through it.
- FSM states: IDLE, PASS1, PASS2, RESP.
- IDLE:
  - If any req_valid is set, grant the first set bit searching from ptr+1 upward, modulo NREQ.
  - Drive req_ready for the granted requester combinationally in the same cycle.
  - Latch a, b, op and id. Set ptr to the granted index. Go to PASS1.
  - If no req_valid is set, stay in IDLE and keep all req_ready low.
- PASS1:
  - Compute tmp = unit(a, b, m=op[0]) and register it.
  - If op[1]=0, set rsp_data=tmp and go to RESP.
  - If op[1]=1, go to PASS2.
- PASS2:
  - Compute rsp_data = unit(tmp, tmp, m=op[0]); this inverts tmp, giving AND or OR.
  - Go to RESP.
- RESP:
  - Hold rsp_valid=1 with rsp_data and rsp_id stable.
  - When rsp_valid && rsp_ready, go to IDLE.
- req_ready is low in every state except IDLE. No new request is accepted while a result is pending.
- A requester may drop req_valid before it is granted; it simply loses eligibility.
- Operands are sampled only in the accept cycle. Later changes on req_a, req_b and req_op are ignored.

## Timing
- Reset values:
  - state=IDLE, ptr=NREQ-1, so requester 0 has first priority.
  - rsp_valid=0, rsp_data=0, rsp_id=0, busy=0, req_ready=0, internal tmp=0.
- Reset asserted in any state returns immediately to the reset values. The in-flight operation is discarded and no response is produced.
- Latency, counting the accept cycle as cycle 0:
  - NAND/NOR: rsp_valid rises in cycle 2.
  - AND/OR: rsp_valid rises in cycle 3.
- Minimum spacing between accepts, with rsp_ready held high: 3 cycles for single-pass ops, 4 cycles for two-pass ops.
- When the response handshake completes in cycle n, the next accept can occur in cycle n+1.
- Backpressure: while rsp_ready=0, rsp_valid, rsp_id and rsp_data are held constant with no limit on duration.
- Fairness: a continuously asserted requester is granted within NREQ accepts.
- ptr changes only on an accept.

## Test plan
- NAND: reset, then req 0 with a=0xF0, b=0xCC, op=00 → req_ready[0] pulses once; rsp_valid in cycle 2; rsp_data=0x3F, rsp_id=0.
- NOR and OR via requester 2: a=0xF0, b=0x0C.
  - op=01 → rsp_data=0x03, latency 2.
  - op=11 → rsp_data=0xFC, latency 3, rsp_id=2.
- AND, two-pass: requester 3, a=0xF0, b=0xCC, op=10 → rsp_data=0xC0 in cycle 3; busy high during cycles 1..3.
- Round-robin: all four req_valid held high with rsp_ready=1 from reset → grant order 0,1,2,3,0,1; never two req_ready bits high at once.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid → rsp_valid/rsp_id/rsp_data stable; req_ready stays 0 despite pending requests; accept happens on the cycle after rsp_ready returns high.
- Reset mid-operation: assert rst_n=0 during PASS2 of an AND → all outputs 0 at once. After release, with req 1 and req 0 both valid, requester 0 is granted first and no stale response appears.
